// File: rtl/uart_tx.sv
// uart_tx: 8N1 byte-serial transmitter, LSB first, line idles high, valid/ready byte input.
module uart_tx #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD_RATE    = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       txd_o,
  input  logic       wvalid_i,
  output logic       wready_o,
  input  logic [7:0] wdata_i
);
  localparam int DIV_RAW = (CLK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
  localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int CW      = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [3:0] bit_idx, bit_n;
  logic [9:0] shift, shift_n;
  logic txd_n, last_baud;
  assign last_baud = baud == CW'(DIV - 1);
  assign wready_o  = state == IDLE;
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    txd_n   = txd_o;
    if (state == IDLE) begin
      if (wvalid_i) begin
        state_n = BUSY;
        shift_n = {1'b1, wdata_i, 1'b0};
        baud_n  = '0;
        bit_n   = '0;
        txd_n   = 1'b0;
      end
    end else if (!last_baud) begin
      baud_n = baud + 1'b1;
    end else begin
      baud_n = '0;
      // shift[1] is the next frame bit; the stop bit is already on the line when bit_idx hits 9
      if (bit_idx == 4'd9) begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end else begin
        bit_n   = bit_idx + 1'b1;
        shift_n = shift >> 1;
        txd_n   = shift[1];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd_o   <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      txd_o   <= txd_n;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed table-driven checks of uart_tx at DIV=100 plus a DIV=1 instance.
module tb_uart_tx;
  localparam int DIV = 100;
  typedef struct {
    logic [7:0] data;
    logic [9:0] slots;
  } vec_t;
  logic clk = 0, rst = 1, wvalid = 0, wvalid1 = 0;
  logic [7:0] wdata = 0, wdata1 = 0;
  logic txd, wready, txd1, wready1;
  int n_cmp = 0, n_err = 0;
  vec_t vecs[6];

  uart_tx #(.CLK_FREQ_MHZ(100), .BAUD_RATE(1000000)) u0 (
    .clk_i(clk), .rst_i(rst), .txd_o(txd), .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata)
  );
  uart_tx #(.CLK_FREQ_MHZ(1), .BAUD_RATE(2000000)) u1 (
    .clk_i(clk), .rst_i(rst), .txd_o(txd1), .wvalid_i(wvalid1), .wready_o(wready1), .wdata_i(wdata1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    while (wready !== 1'b1 && t < 20 * DIV) begin
      tick;
      t++;
    end
    check("send_ready", {31'd0, wready}, 1);
    wvalid = 1;
    wdata  = d;
    tick;
    wvalid = 0;
  endtask

  // Starts on the first cycle of a frame; ends on the first idle cycle after it.
  task automatic check_frame(input string name, input logic [7:0] d, input logic [9:0] slots, input int inj);
    int ones, rdy, cyc;
    logic [7:0] rx;
    rdy = 0;
    rx  = 0;
    for (int s = 0; s < 10; s++) begin
      ones = 0;
      for (int c = 0; c < DIV; c++) begin
        cyc = s * DIV + c;
        if (cyc == inj) begin
          wvalid = 1;
          wdata  = 8'hFF;
        end else if (cyc == inj + 1) begin
          wvalid = 0;
          wdata  = 8'h5A;
        end
        ones += (txd === 1'b1) ? 1 : 0;
        rdy  += (wready === 1'b1) ? 1 : 0;
        if (c == DIV / 2 && s >= 1 && s <= 8) rx[s-1] = txd;
        tick;
      end
      check($sformatf("%s slot%0d high_cycles", name, s), ones, slots[s] ? DIV : 0);
    end
    check({name, " busy_ready_cycles"}, rdy, 0);
    check({name, " rx_byte"}, {24'd0, rx}, {24'd0, d});
    check({name, " end_ready"}, {31'd0, wready}, 1);
    check({name, " end_txd"}, {31'd0, txd}, 1);
  endtask

  initial begin
    int lows;
    logic [9:0] bits;
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h55, 10'b1010101010};
    vecs[4] = '{8'h0F, 10'b1000011110};
    vecs[5] = '{8'h81, 10'b1100000010};
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst_txd", {31'd0, txd}, 1);
      check("rst_ready", {31'd0, wready}, 1);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("post_rst_txd", {31'd0, txd}, 1);
      check("post_rst_ready", {31'd0, wready}, 1);
    end
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      check_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].slots, -1);
      tick;
    end
    send(8'h00);
    check_frame("busy_ignore", 8'h00, 10'b1000000000, 300);
    lows = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      lows += (txd !== 1'b1 ? 1 : 0) + (wready !== 1'b1 ? 1 : 0);
      tick;
    end
    check("no_second_frame", lows, 0);
    send(8'h55);
    check_frame("b2b_first", 8'h55, 10'b1010101010, -1);
    wvalid = 1;
    wdata  = 8'h0F;
    tick;
    wvalid = 0;
    check_frame("b2b_second", 8'h0F, 10'b1000011110, -1);
    send(8'hA5);
    repeat (450) tick;
    rst = 1;
    tick;
    rst = 0;
    check("mid_rst_txd", {31'd0, txd}, 1);
    check("mid_rst_ready", {31'd0, wready}, 1);
    send(8'h3C);
    check_frame("after_rst", 8'h3C, 10'b1001111000, -1);
    wvalid1 = 1;
    wdata1  = 8'hA5;
    tick;
    wvalid1 = 0;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      bits[k] = txd1;
      lows += (wready1 === 1'b1) ? 1 : 0;
      tick;
    end
    check("div1_bits", {22'd0, bits}, {22'd0, 10'b1101001010});
    check("div1_busy_ready", lows, 0);
    check("div1_end_ready", {31'd0, wready1}, 1);
    check("div1_end_txd", {31'd0, txd1}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
